// File: rtl/l2_mem_pkg.sv
// -----------------------------------------------------------------------------
// l2_mem_pkg
// Shared definitions for the L2 miss/writeback sequencer:
//   - default widths (byte address, cache line) and the watchdog limit
//   - LINE_OFS: number of byte-offset bits inside a line (64-byte lines)
//   - FSM state encoding (3-bit) and the state enum built on it
// -----------------------------------------------------------------------------
package l2_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 512;
  localparam int unsigned TO_CYC_DEF = 1024;
  localparam int unsigned LINE_OFS   = 6;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_WB_ENC   = 3'd1;
  localparam logic [2:0] ST_GAP_ENC  = 3'd2;
  localparam logic [2:0] ST_RD_ENC   = 3'd3;
  localparam logic [2:0] ST_RESP_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_WB   = ST_WB_ENC,
    ST_GAP  = ST_GAP_ENC,
    ST_RD   = ST_RD_ENC,
    ST_RESP = ST_RESP_ENC
  } state_e;

endpackage

// File: rtl/l2_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// l2_mem_ctrl_if
// Memory-side bus between the L2 sequencer and main memory.
//   read_L2_MEM        master->slave  read request, level, held until ready
//   write_L2_MEM       master->slave  write request, level, held until ready
//   address_L2_MEM     master->slave  line-aligned address
//   write_data_L2_MEM  master->slave  writeback line
//   ready_MEM_L2       slave->master  one-cycle completion pulse
//   read_data_MEM_L2   slave->master  read line, valid with ready_MEM_L2
// Modports: master (the sequencer), slave (the memory).
// -----------------------------------------------------------------------------
interface l2_mem_ctrl_if
  import l2_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
);

  logic              read_L2_MEM;
  logic              write_L2_MEM;
  logic [ADDR_W-1:0] address_L2_MEM;
  logic [LINE_W-1:0] write_data_L2_MEM;
  logic              ready_MEM_L2;
  logic [LINE_W-1:0] read_data_MEM_L2;

  modport master (
    output read_L2_MEM, write_L2_MEM, address_L2_MEM, write_data_L2_MEM,
    input  ready_MEM_L2, read_data_MEM_L2
  );

  modport slave (
    input  read_L2_MEM, write_L2_MEM, address_L2_MEM, write_data_L2_MEM,
    output ready_MEM_L2, read_data_MEM_L2
  );

endinterface

// File: rtl/l2_mem_ctrl.sv
// -----------------------------------------------------------------------------
// l2_mem_ctrl
// Miss/writeback sequencer between the L2 cache and main memory. Takes one
// line request at a time: writes back a dirty victim first, leaves one idle
// cycle on the memory bus, then reads the missing line and hands it back to
// L2 as a one-cycle response pulse.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid_L2        in   request valid, held by L2 until req_ready_L2
//   req_ready_L2        out  idle, request accepted this cycle
//   req_addr_L2         in   refill line address
//   req_rd_L2           in   refill wanted (0 = writeback only)
//   req_dirty_L2        in   victim dirty, write it back first
//   req_victim_addr_L2  in   victim line address
//   req_wdata_L2        in   victim line data
//   resp_valid_L2       out  one-cycle completion pulse
//   resp_data_L2        out  refill line (holds until the next read capture)
//   mem                 memory bus (l2_mem_ctrl_if.master)
//   err_timeout         out  sticky watchdog flag
//
// Build option
//   L2_MEM_TIMEOUT_EN   enables the TO_CYC watchdog on WB/RD; without it the
//                       controller waits for memory indefinitely and
//                       err_timeout is tied low.
// -----------------------------------------------------------------------------
module l2_mem_ctrl
  import l2_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned TO_CYC = TO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_L2,
  output logic              req_ready_L2,
  input  logic [ADDR_W-1:0] req_addr_L2,
  input  logic              req_rd_L2,
  input  logic              req_dirty_L2,
  input  logic [ADDR_W-1:0] req_victim_addr_L2,
  input  logic [LINE_W-1:0] req_wdata_L2,
  output logic              resp_valid_L2,
  output logic [LINE_W-1:0] resp_data_L2,
  l2_mem_ctrl_if.master     mem,
  output logic              err_timeout
);

  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-LINE_OFS){1'b1}}, {LINE_OFS{1'b0}}};

  state_e state_q, state_d;

  // Latched request fields
  logic [ADDR_W-1:0] lat_addr_q,   lat_addr_d;
  logic [ADDR_W-1:0] lat_victim_q, lat_victim_d;
  logic [LINE_W-1:0] lat_wdata_q,  lat_wdata_d;
  logic              lat_rd_q,     lat_rd_d;

  // Registered outputs
  logic              req_ready_q,  req_ready_d;
  logic              read_q,       read_d;
  logic              write_q,      write_d;
  logic [ADDR_W-1:0] addr_q,       addr_d;
  logic [LINE_W-1:0] wdata_q,      wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic [LINE_W-1:0] resp_data_q,  resp_data_d;

  logic accept;
  logic timeout_hit;

  // req_ready_q is only ever high while state_q is IDLE
  assign accept = req_ready_q & req_valid_L2;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lat_addr_q   <= {ADDR_W{1'b0}};
      lat_victim_q <= {ADDR_W{1'b0}};
      lat_wdata_q  <= {LINE_W{1'b0}};
      lat_rd_q     <= 1'b0;
      req_ready_q  <= 1'b0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {LINE_W{1'b0}};
      resp_valid_q <= 1'b0;
      resp_data_q  <= {LINE_W{1'b0}};
    end else begin
      state_q      <= state_d;
      lat_addr_q   <= lat_addr_d;
      lat_victim_q <= lat_victim_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_rd_q     <= lat_rd_d;
      req_ready_q  <= req_ready_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  // Next-state logic; a memory ready wins over a watchdog expiry in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (req_dirty_L2) begin
            state_d = ST_WB;
          end else if (req_rd_L2) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        if (mem.ready_MEM_L2) begin
          state_d = lat_rd_q ? ST_GAP : ST_RESP;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_GAP:  state_d = ST_RD;
      ST_RD: begin
        if (mem.ready_MEM_L2 || timeout_hit) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: outputs are registered from the next state, so they line up
  // with state_q. In the accept cycle the fields come straight from the inputs
  // because the latches are not loaded yet.
  always_comb begin
    if (accept) begin
      lat_addr_d   = req_addr_L2;
      lat_victim_d = req_victim_addr_L2;
      lat_wdata_d  = req_wdata_L2;
      lat_rd_d     = req_rd_L2;
    end else begin
      lat_addr_d   = lat_addr_q;
      lat_victim_d = lat_victim_q;
      lat_wdata_d  = lat_wdata_q;
      lat_rd_d     = lat_rd_q;
    end

    req_ready_d  = (state_d == ST_IDLE);
    write_d      = (state_d == ST_WB);
    read_d       = (state_d == ST_RD);
    resp_valid_d = (state_d == ST_RESP);

    case (state_d)
      ST_WB: begin
        addr_d  = lat_victim_d & LINE_MASK;
        wdata_d = lat_wdata_d;
      end
      ST_RD: begin
        addr_d  = lat_addr_d & LINE_MASK;
        wdata_d = {LINE_W{1'b0}};
      end
      default: begin
        addr_d  = {ADDR_W{1'b0}};
        wdata_d = {LINE_W{1'b0}};
      end
    endcase

    if ((state_q == ST_RD) && mem.ready_MEM_L2) begin
      resp_data_d = mem.read_data_MEM_L2;
    end else begin
      resp_data_d = resp_data_q;
    end
  end

  assign req_ready_L2          = req_ready_q;
  assign resp_valid_L2         = resp_valid_q;
  assign resp_data_L2          = resp_data_q;
  assign mem.read_L2_MEM       = read_q;
  assign mem.write_L2_MEM      = write_q;
  assign mem.address_L2_MEM    = addr_q;
  assign mem.write_data_L2_MEM = wdata_q;

`ifdef L2_MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TO_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Watchdog: count cycles spent waiting in WB/RD, fire on the TO_CYC-th one
  always_comb begin
    if (((state_q == ST_WB) || (state_q == ST_RD)) && !mem.ready_MEM_L2 &&
        (cnt_q == CNT_W'(TO_CYC - 1))) begin
      timeout_hit = 1'b1;
    end else begin
      timeout_hit = 1'b0;
    end

    if (((state_q == ST_WB) || (state_q == ST_RD)) && (state_d == state_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end

    err_d = err_q | timeout_hit;
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_l2_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_l2_mem_ctrl
// Directed bench for l2_mem_ctrl. Each task drives one scenario and checks the
// outputs cycle by cycle against hand-derived values. Inputs change and
// outputs are sampled on the falling clock edge.
// ctl = {req_ready, read, write, resp_valid, err_timeout}.
// -----------------------------------------------------------------------------
module tb_l2_mem_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid_L2;
  logic         req_ready_L2;
  logic [31:0]  req_addr_L2;
  logic         req_rd_L2;
  logic         req_dirty_L2;
  logic [31:0]  req_victim_addr_L2;
  logic [511:0] req_wdata_L2;
  logic         resp_valid_L2;
  logic [511:0] resp_data_L2;
  logic         err_timeout;

  int tests_run = 0;
  int fails     = 0;

  logic [511:0] d1, d2, d3, d4, d5, d6, d7, db;

  l2_mem_ctrl_if #(.ADDR_W(32), .LINE_W(512)) mif ();

  l2_mem_ctrl #(.ADDR_W(32), .LINE_W(512), .TO_CYC(8)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_L2       (req_valid_L2),
    .req_ready_L2       (req_ready_L2),
    .req_addr_L2        (req_addr_L2),
    .req_rd_L2          (req_rd_L2),
    .req_dirty_L2       (req_dirty_L2),
    .req_victim_addr_L2 (req_victim_addr_L2),
    .req_wdata_L2       (req_wdata_L2),
    .resp_valid_L2      (resp_valid_L2),
    .resp_data_L2       (resp_data_L2),
    .mem                (mif.master),
    .err_timeout        (err_timeout)
  );

  always #5 clk = ~clk;

  wire [4:0] ctl = {req_ready_L2, mif.read_L2_MEM, mif.write_L2_MEM, resp_valid_L2, err_timeout};

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [31:0] a, input logic rd, input logic dirty,
                         input logic [31:0] va, input logic [511:0] wd);
    req_addr_L2        = a;
    req_rd_L2          = rd;
    req_dirty_L2       = dirty;
    req_victim_addr_L2 = va;
    req_wdata_L2       = wd;
  endtask

  task automatic mem_pulse(input logic [511:0] data);
    mif.ready_MEM_L2     = 1'b1;
    mif.read_data_MEM_L2 = data;
    step();
    mif.ready_MEM_L2     = 1'b0;
    mif.read_data_MEM_L2 = 512'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({ctl, mif.address_L2_MEM} !== {5'b00000, 32'h0}) begin
      fails++; $display("FAIL reset_ctl ctl=%b addr=%h exp ctl=00000 addr=0", ctl, mif.address_L2_MEM);
    end
    tests_run++;
    if ({mif.write_data_L2_MEM, resp_data_L2} !== 1024'd0) begin
      fails++; $display("FAIL reset_data wdata=%h rdata=%h exp 0", mif.write_data_L2_MEM, resp_data_L2);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (ctl !== 5'b10000) begin fails++; $display("FAIL reset_idle ctl=%b exp 10000", ctl); end
  endtask

  task automatic test_clean_refill();
    set_req(32'h0000_1040, 1'b1, 1'b0, 32'h0, 512'd0);
    req_valid_L2 = 1'b1;
    step();
    req_valid_L2 = 1'b0;
    tests_run++;
    if ({ctl, mif.address_L2_MEM} !== {5'b01000, 32'h0000_1040}) begin
      fails++; $display("FAIL clean_rd1 ctl=%b addr=%h exp 01000 00001040", ctl, mif.address_L2_MEM);
    end
    step();
    tests_run++;
    if (ctl !== 5'b01000) begin fails++; $display("FAIL clean_rd2 ctl=%b exp 01000", ctl); end
    step();
    tests_run++;
    if (ctl !== 5'b01000) begin fails++; $display("FAIL clean_rd3 ctl=%b exp 01000", ctl); end
    mem_pulse(d1);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00010, d1}) begin
      fails++; $display("FAIL clean_resp ctl=%b data=%h exp 00010 %h", ctl, resp_data_L2, d1);
    end
    step();
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b10000, d1}) begin
      fails++; $display("FAIL clean_done ctl=%b data=%h exp 10000 %h", ctl, resp_data_L2, d1);
    end
  endtask

  task automatic test_dirty_refill();
    set_req(32'h0000_3025, 1'b1, 1'b1, 32'h0000_2000, db);
    req_valid_L2 = 1'b1;
    step();
    req_valid_L2 = 1'b0;
    tests_run++;
    if ({ctl, mif.address_L2_MEM} !== {5'b00100, 32'h0000_2000}) begin
      fails++; $display("FAIL dirty_wb ctl=%b addr=%h exp 00100 00002000", ctl, mif.address_L2_MEM);
    end
    tests_run++;
    if (mif.write_data_L2_MEM !== db) begin
      fails++; $display("FAIL dirty_wdata got=%h exp=%h", mif.write_data_L2_MEM, db);
    end
    mem_pulse(512'd0);
    tests_run++;
    if (ctl !== 5'b00000) begin fails++; $display("FAIL dirty_gap ctl=%b exp 00000", ctl); end
    step();
    tests_run++;
    if ({ctl, mif.address_L2_MEM} !== {5'b01000, 32'h0000_3000}) begin
      fails++; $display("FAIL dirty_rd ctl=%b addr=%h exp 01000 00003000", ctl, mif.address_L2_MEM);
    end
    mem_pulse(d2);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00010, d2}) begin
      fails++; $display("FAIL dirty_resp ctl=%b data=%h exp 00010 %h", ctl, resp_data_L2, d2);
    end
    step();
    tests_run++;
    if (ctl !== 5'b10000) begin fails++; $display("FAIL dirty_done ctl=%b exp 10000", ctl); end
  endtask

  task automatic test_wb_only();
    set_req(32'h0000_5000, 1'b0, 1'b1, 32'h0000_40BF, d3);
    req_valid_L2 = 1'b1;
    step();
    req_valid_L2 = 1'b0;
    tests_run++;
    if ({ctl, mif.address_L2_MEM, mif.write_data_L2_MEM} !== {5'b00100, 32'h0000_4080, d3}) begin
      fails++; $display("FAIL wbo_wr ctl=%b addr=%h exp 00100 00004080", ctl, mif.address_L2_MEM);
    end
    step();
    tests_run++;
    if (ctl !== 5'b00100) begin fails++; $display("FAIL wbo_hold ctl=%b exp 00100", ctl); end
    mem_pulse(d4);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00010, d2}) begin
      fails++; $display("FAIL wbo_resp ctl=%b data=%h exp 00010 %h", ctl, resp_data_L2, d2);
    end
    step();
    tests_run++;
    if (ctl !== 5'b10000) begin fails++; $display("FAIL wbo_done ctl=%b exp 10000", ctl); end
    mem_pulse(d4);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b10000, d2}) begin
      fails++; $display("FAIL stray_ready ctl=%b data=%h exp 10000 %h", ctl, resp_data_L2, d2);
    end
  endtask

  task automatic test_back_to_back();
    set_req(32'h0000_5000, 1'b1, 1'b0, 32'h0, 512'd0);
    req_valid_L2 = 1'b1;
    step();
    tests_run++;
    if ({ctl, mif.address_L2_MEM} !== {5'b01000, 32'h0000_5000}) begin
      fails++; $display("FAIL b2b_rd1 ctl=%b addr=%h exp 01000 00005000", ctl, mif.address_L2_MEM);
    end
    set_req(32'h0000_6000, 1'b1, 1'b0, 32'h0, 512'd0);
    mem_pulse(d4);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00010, d4}) begin
      fails++; $display("FAIL b2b_resp1 ctl=%b data=%h exp 00010 %h", ctl, resp_data_L2, d4);
    end
    step();
    tests_run++;
    if (ctl !== 5'b10000) begin fails++; $display("FAIL b2b_accept ctl=%b exp 10000", ctl); end
    step();
    req_valid_L2 = 1'b0;
    tests_run++;
    if ({ctl, mif.address_L2_MEM} !== {5'b01000, 32'h0000_6000}) begin
      fails++; $display("FAIL b2b_rd2 ctl=%b addr=%h exp 01000 00006000", ctl, mif.address_L2_MEM);
    end
    mem_pulse(d5);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00010, d5}) begin
      fails++; $display("FAIL b2b_resp2 ctl=%b data=%h exp 00010 %h", ctl, resp_data_L2, d5);
    end
    step();
  endtask

  task automatic test_reset_mid();
    set_req(32'h0000_7000, 1'b1, 1'b0, 32'h0, 512'd0);
    req_valid_L2 = 1'b1;
    step();
    req_valid_L2 = 1'b0;
    step();
    tests_run++;
    if (ctl !== 5'b01000) begin fails++; $display("FAIL rstmid_rd ctl=%b exp 01000", ctl); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({ctl, mif.address_L2_MEM, resp_data_L2} !== {5'b00000, 32'h0, 512'd0}) begin
      fails++; $display("FAIL rstmid_async ctl=%b addr=%h exp 00000 0", ctl, mif.address_L2_MEM);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    set_req(32'h0000_7040, 1'b1, 1'b0, 32'h0, 512'd0);
    req_valid_L2 = 1'b1;
    step();
    req_valid_L2 = 1'b0;
    tests_run++;
    if ({ctl, mif.address_L2_MEM} !== {5'b01000, 32'h0000_7040}) begin
      fails++; $display("FAIL rstmid_rd2 ctl=%b addr=%h exp 01000 00007040", ctl, mif.address_L2_MEM);
    end
    mem_pulse(d6);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00010, d6}) begin
      fails++; $display("FAIL rstmid_resp ctl=%b data=%h exp 00010 %h", ctl, resp_data_L2, d6);
    end
    step();
  endtask

`ifdef L2_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int rd_cnt;
    rd_cnt = 0;
    set_req(32'h0000_8000, 1'b1, 1'b0, 32'h0, 512'd0);
    req_valid_L2 = 1'b1;
    step();
    req_valid_L2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ctl === 5'b01000) rd_cnt++;
      step();
    end
    tests_run++;
    if (rd_cnt !== 8) begin fails++; $display("FAIL to_rdcycles got=%0d exp=8", rd_cnt); end
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00011, d6}) begin
      fails++; $display("FAIL to_fire ctl=%b data=%h exp 00011 %h", ctl, resp_data_L2, d6);
    end
    step();
    tests_run++;
    if (ctl !== 5'b10001) begin fails++; $display("FAIL to_sticky ctl=%b exp 10001", ctl); end
    set_req(32'h0000_9000, 1'b1, 1'b0, 32'h0, 512'd0);
    req_valid_L2 = 1'b1;
    step();
    req_valid_L2 = 1'b0;
    mem_pulse(d7);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00011, d7}) begin
      fails++; $display("FAIL to_after ctl=%b data=%h exp 00011 %h", ctl, resp_data_L2, d7);
    end
    step();
    rst = 1'b1;
    #1;
    tests_run++;
    if (ctl !== 5'b00000) begin fails++; $display("FAIL to_clear ctl=%b exp 00000", ctl); end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask
`else
  task automatic test_timeout();
    set_req(32'h0000_8000, 1'b1, 1'b0, 32'h0, 512'd0);
    req_valid_L2 = 1'b1;
    step();
    req_valid_L2 = 1'b0;
    repeat (20) step();
    tests_run++;
    if (ctl !== 5'b01000) begin fails++; $display("FAIL nowd_wait ctl=%b exp 01000", ctl); end
    mem_pulse(d7);
    tests_run++;
    if ({ctl, resp_data_L2} !== {5'b00010, d7}) begin
      fails++; $display("FAIL nowd_resp ctl=%b data=%h exp 00010 %h", ctl, resp_data_L2, d7);
    end
    step();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    d1 = {8{64'h0123_4567_89AB_CDEF}};
    d2 = {16{32'hCAFE_F00D}};
    d3 = {32{16'hA5C3}};
    d4 = {8{64'h1111_2222_3333_4444}};
    d5 = {16{32'h5A5A_0F0F}};
    d6 = {64{8'h96}};
    d7 = {8{64'hFEDC_BA98_7654_3210}};
    db = {16{32'hDEAD_BEEF}};
    rst = 1'b1;
    req_valid_L2 = 1'b0;
    set_req(32'h0, 1'b0, 1'b0, 32'h0, 512'd0);
    mif.ready_MEM_L2     = 1'b0;
    mif.read_data_MEM_L2 = 512'd0;

    test_reset();
    test_clean_refill();
    test_dirty_refill();
    test_wb_only();
    test_back_to_back();
    test_reset_mid();
    test_timeout();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
